hs_inband_cons: RTL and testbench
=================================

// Module: hs_inband_cons
// PURPOSE
//  Consumer end of the inband command ring. Polls inband_prod_index against its own consumer index.
//  Fetches each pending 2-dword entry through a single-beat memory read port.
//  Replays the entry as a CmdReq/CmdAck transaction toward the command interface, then advances inband_cons_index.
//  Sits between the mb_io ring registers and the command-interface responder.
// PARAMETERS
//  C_RING_DEPTH   4096  entries in ring; power of 2, <=4096; index wraps modulo depth
//  C_ACK_TIMEOUT  1024  cycles to wait for CmdAck (used only with HS_INBAND_CONS_TIMEOUT_EN)
// PORTS
//  sys_clk            in   1   clock
//  sys_rst            in   1   synchronous reset, active high
//  PhyReady           in   1   link ready; no new entry fetched while low
//  inband_base        in   32  byte address of ring entry 0 (8-byte aligned)
//  inband_prod_index  in   12  producer index
//  inband_cons_index  out  12  consumer index (next entry to consume)
//  MemRdReq           out  1   read request, held until MemRdValid
//  MemRdAddr          out  32  read byte address, stable while MemRdReq
//  MemRdValid         in   1   MemRdData valid; completes the read
//  MemRdData          in   32  read data
//  CmdReq             out  1   command request, held until CmdAck
//  CmdAck             in   1   command accepted
//  CmdId              out  5   entry word0[20:16]
//  CmdAddr            out  4   entry word0[3:0]
//  CmdWr              out  1   entry word0[31]
//  Cmd                out  32  entry word1
//  CmdTimeout         out  1   one-cycle pulse: command dropped on ack timeout
// BEHAVIOUR
//  - Reset: state IDLE.
//    inband_cons_index, MemRdReq, MemRdAddr, CmdReq, CmdId, CmdAddr, CmdWr, Cmd and CmdTimeout all reset to 0.
//  - Entry n layout: word0 at inband_base + n*8; word1 at inband_base + n*8 + 4.
//    word0 bits other than 31, 20:16 and 3:0 are ignored.
//  - FSM: IDLE -> RD0 -> RD1 -> ISSUE -> ADV -> IDLE.
//  - IDLE: leave only when PhyReady=1 and prod_index != cons_index. Equal indices mean empty; stay in IDLE.
//  - RD0: MemRdReq=1, MemRdAddr=word0 address.
//    On the MemRdValid cycle: capture CmdWr/CmdId/CmdAddr, drop MemRdReq, go to RD1.
//  - RD1: same as RD0 for word1. On the MemRdValid cycle: capture Cmd, go to ISSUE.
//  - Back-to-back: the read of the next word, or the CmdReq assertion, starts on the cycle after MemRdValid.
//  - MemRdValid is ignored in any state other than RD0 and RD1.
//  - ISSUE: CmdReq=1; CmdId/CmdAddr/CmdWr/Cmd held stable.
//    On the CmdAck cycle: drop CmdReq, go to ADV.
//    CmdAck outside ISSUE is ignored.
//  - ADV: cons_index <= (cons_index+1) mod C_RING_DEPTH, i.e. depth-1 wraps to 0. Return to IDLE.
//    The new index is visible on the cycle after ADV.
//  - Minimum per-entry cost: 5 cycles, with 0-wait memory and immediate ack.
//  - prod_index is sampled only in IDLE; it may change at any time without effect mid-entry.
//  - PhyReady falling mid-entry does not abort; the current entry completes.
//  - A ring-full producer state (prod = cons-1) is legal and is simply drained.
//  - Address arithmetic: 32-bit, modulo 2^32; index zero-extended and shifted left 3.
//  - sys_rst mid-operation: immediate return to IDLE, cons_index=0, requests dropped next edge; partial entry discarded.
// CONFIGURATION
//  - Macro: HS_INBAND_CONS_TIMEOUT_EN.
//  - Defined: a 16-bit counter clears on entering ISSUE and counts each ISSUE cycle without CmdAck.
//    On reaching C_ACK_TIMEOUT: CmdReq drops, CmdTimeout pulses 1 cycle, FSM goes to ADV (entry skipped).
//    CmdAck on the same cycle as expiry wins: no pulse.
//  - Undefined: no counter; ISSUE waits indefinitely; CmdTimeout tied 0.
// TESTING
//  - Empty ring: base=0x1000, prod=cons=0, PhyReady=1 -> no MemRdReq for 100 cycles; cons_index stays 0.
//  - Single entry: prod=1, word0=0x8003_0005, word1=0xDEAD_BEEF, 0-wait memory -> reads at 0x1000 then 0x1004.
//    Then CmdWr=1, CmdId=3, CmdAddr=5, Cmd=0xDEADBEEF. Ack next cycle -> cons_index=1.
//  - Wrap: C_RING_DEPTH=8, cons=7, prod=1 -> entries 7 and 0 consumed; reads at base+0x38, then base+0x0; cons_index ends 1.
//  - PhyReady gating: prod=2, PhyReady=0 -> no read. Raise PhyReady -> both entries consumed; CmdReq held 10 cycles until delayed CmdAck.
//  - Reset mid-ISSUE: sys_rst for 1 cycle with CmdReq=1 -> next cycle CmdReq=0, cons_index=0; refetch of entry 0 follows.
//  - Timeout (macro on, C_ACK_TIMEOUT=16): CmdAck never asserted -> CmdReq drops after 16 cycles, CmdTimeout pulses once, cons_index increments.

Source files
------------

// File: rtl/hs_inband_cons_if.sv
// -----------------------------------------------------------------------------
// hs_inband_cons_if
// Purpose : bundles the two handshakes of the inband command consumer:
//           the single-beat memory read port used to fetch ring entries, and
//           the CmdReq/CmdAck command interface the entries are replayed on.
// Signals :
//   MemRdReq    consumer -> memory   read request, held until MemRdValid
//   MemRdAddr   consumer -> memory   read byte address, stable while MemRdReq
//   MemRdValid  memory -> consumer   MemRdData valid, completes the read
//   MemRdData   memory -> consumer   read data
//   CmdReq      consumer -> responder command request, held until CmdAck
//   CmdAck      responder -> consumer command accepted
//   CmdId       consumer -> responder entry word0[20:16]
//   CmdAddr     consumer -> responder entry word0[3:0]
//   CmdWr       consumer -> responder entry word0[31]
//   Cmd         consumer -> responder entry word1
//   CmdTimeout  consumer -> responder one-cycle pulse, command dropped on timeout
// Modports: master = consumer side, slave = memory/responder side.
// -----------------------------------------------------------------------------
interface hs_inband_cons_if;
  logic        MemRdReq;
  logic [31:0] MemRdAddr;
  logic        MemRdValid;
  logic [31:0] MemRdData;
  logic        CmdReq;
  logic        CmdAck;
  logic [4:0]  CmdId;
  logic [3:0]  CmdAddr;
  logic        CmdWr;
  logic [31:0] Cmd;
  logic        CmdTimeout;

  modport master (
    output MemRdReq, MemRdAddr,
    input  MemRdValid, MemRdData,
    output CmdReq,
    input  CmdAck,
    output CmdId, CmdAddr, CmdWr, Cmd, CmdTimeout
  );

  modport slave (
    input  MemRdReq, MemRdAddr,
    output MemRdValid, MemRdData,
    input  CmdReq,
    output CmdAck,
    input  CmdId, CmdAddr, CmdWr, Cmd, CmdTimeout
  );
endinterface : hs_inband_cons_if

// File: rtl/hs_inband_cons.sv
// -----------------------------------------------------------------------------
// hs_inband_cons
// Purpose : consumer end of the inband command ring. While PhyReady is high
//           and the producer index differs from the consumer index, fetches
//           the 2-dword entry at inband_base + cons*8 through the memory read
//           port, replays it as a CmdReq/CmdAck transaction and then advances
//           the consumer index (modulo C_RING_DEPTH).
// Parameters:
//   C_RING_DEPTH   entries in the ring, power of 2, <= 4096
//   C_ACK_TIMEOUT  ISSUE cycles to wait for CmdAck before dropping the entry
// Ports   :
//   sys_clk            clock
//   sys_rst            synchronous reset, active high
//   PhyReady           link ready; gates the start of a new entry only
//   inband_base        byte address of ring entry 0 (8-byte aligned)
//   inband_prod_index  producer index, sampled only while idle
//   inband_cons_index  consumer index (next entry to consume)
//   bus                hs_inband_cons_if.master: memory read + command ports
// Configuration:
//   HS_INBAND_CONS_TIMEOUT_EN  defined: ack timeout counter, CmdTimeout pulse.
//                              undefined: ISSUE waits forever, CmdTimeout = 0.
// -----------------------------------------------------------------------------
module hs_inband_cons #(
  parameter int unsigned C_RING_DEPTH  = 4096,
  parameter int unsigned C_ACK_TIMEOUT = 1024
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    PhyReady,
  input  logic [31:0]             inband_base,
  input  logic [11:0]             inband_prod_index,
  output logic [11:0]             inband_cons_index,
  hs_inband_cons_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_ISSUE,
    S_ADV
  } state_t;

  localparam logic [11:0] C_IDX_MASK = 12'(C_RING_DEPTH - 1);

  state_t      r_state;
  logic [11:0] r_cons_index;
  logic        r_mem_rd_req;
  logic [31:0] r_mem_rd_addr;
  logic        r_cmd_req;
  logic [4:0]  r_cmd_id;
  logic [3:0]  r_cmd_addr;
  logic        r_cmd_wr;
  logic [31:0] r_cmd;

  logic [11:0] w_prod_index;
  logic        w_pending;
  logic [31:0] w_entry_addr;

  // Producer index is reduced to ring range so an out-of-range value cannot
  // make the ring look permanently non-empty.
  assign w_prod_index = inband_prod_index & C_IDX_MASK;
  assign w_pending    = (w_prod_index != r_cons_index);
  // Entry n lives at base + n*8; wraps modulo 2^32.
  assign w_entry_addr = inband_base + {17'd0, r_cons_index, 3'b000};

`ifdef HS_INBAND_CONS_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_cmd_timeout;
  logic        w_to_expired;

  assign w_to_expired = (r_to_cnt == 16'(C_ACK_TIMEOUT - 1));
`endif

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // takes effect only on the next sys_clk edge.
  // NOTE: every state register uses non-blocking assignment so all updates
  // in this block see the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= S_IDLE;
      r_cons_index  <= '0;
      r_mem_rd_req  <= 1'b0;
      r_mem_rd_addr <= '0;
      r_cmd_req     <= 1'b0;
      r_cmd_id      <= '0;
      r_cmd_addr    <= '0;
      r_cmd_wr      <= 1'b0;
      r_cmd         <= '0;
`ifdef HS_INBAND_CONS_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_cmd_timeout <= 1'b0;
`endif
    end else begin
`ifdef HS_INBAND_CONS_TIMEOUT_EN
      r_cmd_timeout <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (PhyReady && w_pending) begin
            r_mem_rd_req  <= 1'b1;
            r_mem_rd_addr <= w_entry_addr;
            r_state       <= S_RD0;
          end
        end

        S_RD0: begin
          if (bus.MemRdValid) begin
            r_cmd_wr      <= bus.MemRdData[31];
            r_cmd_id      <= bus.MemRdData[20:16];
            r_cmd_addr    <= bus.MemRdData[3:0];
            // The word0 read completes here and the word1 read starts on the
            // very next cycle, so the request simply stays high with the new
            // address rather than dipping for one cycle.
            r_mem_rd_addr <= r_mem_rd_addr + 32'd4;
            r_state       <= S_RD1;
          end
        end

        S_RD1: begin
          if (bus.MemRdValid) begin
            r_cmd        <= bus.MemRdData;
            r_mem_rd_req <= 1'b0;
            r_cmd_req    <= 1'b1;
`ifdef HS_INBAND_CONS_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
            r_state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (bus.CmdAck) begin
            r_cmd_req <= 1'b0;
            r_state   <= S_ADV;
          end
`ifdef HS_INBAND_CONS_TIMEOUT_EN
          // Ack on the expiry cycle takes the branch above: no pulse.
          else if (w_to_expired) begin
            r_cmd_req     <= 1'b0;
            r_cmd_timeout <= 1'b1;
            r_state       <= S_ADV;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
`endif
        end

        S_ADV: begin
          r_cons_index <= (r_cons_index + 12'd1) & C_IDX_MASK;
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inband_cons_index = r_cons_index;
  assign bus.MemRdReq      = r_mem_rd_req;
  assign bus.MemRdAddr     = r_mem_rd_addr;
  assign bus.CmdReq        = r_cmd_req;
  assign bus.CmdId         = r_cmd_id;
  assign bus.CmdAddr       = r_cmd_addr;
  assign bus.CmdWr         = r_cmd_wr;
  assign bus.Cmd           = r_cmd;
`ifdef HS_INBAND_CONS_TIMEOUT_EN
  assign bus.CmdTimeout    = r_cmd_timeout;
`else
  assign bus.CmdTimeout    = 1'b0;
`endif

endmodule : hs_inband_cons

// File: tb/tb_hs_inband_cons.sv
// -----------------------------------------------------------------------------
// tb_hs_inband_cons
// Directed bench for hs_inband_cons (ring depth 8, ack timeout 16). A small
// memory holds eight hand-written ring entries; a combinational responder
// returns reads with zero wait (optionally stalled) and acks either
// immediately or under manual control. Completed reads and commands are
// logged at the clock edge and compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_hs_inband_cons;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        PhyReady;
  logic [31:0] inband_base;
  logic [11:0] inband_prod_index;
  logic [11:0] inband_cons_index;

  hs_inband_cons_if bus ();

  hs_inband_cons #(
    .C_RING_DEPTH (8),
    .C_ACK_TIMEOUT(16)
  ) u_dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .PhyReady         (PhyReady),
    .inband_base      (inband_base),
    .inband_prod_index(inband_prod_index),
    .inband_cons_index(inband_cons_index),
    .bus              (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------- responders
  logic [31:0] mem [16];
  logic        mem_en;
  logic        auto_ack;
  logic        man_ack;

  assign bus.MemRdValid = bus.MemRdReq && mem_en;
  assign bus.MemRdData  = mem[bus.MemRdAddr[5:2]];
  assign bus.CmdAck     = auto_ack ? bus.CmdReq : man_ack;

  // ---------------------------------------------------------------- monitors
  logic [31:0] rd_log  [$];
  logic [41:0] cmd_log [$];
  int          to_count;

  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (bus.MemRdReq && bus.MemRdValid) rd_log.push_back(bus.MemRdAddr);
      if (bus.CmdReq && bus.CmdAck)
        cmd_log.push_back({bus.CmdWr, bus.CmdId, bus.CmdAddr, bus.Cmd});
      if (bus.CmdTimeout) to_count++;
    end
  end

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cons(input logic [11:0] target, input int budget, input string tag);
    int n = 0;
    while (inband_cons_index !== target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, 64'(inband_cons_index), 64'(target));
  endtask

  // Expected command fields {wr, id, addr, word1} per entry, hand-decoded.
  localparam logic [41:0] EXP_E0 = {1'b1, 5'd3,    4'd5,   32'hDEAD_BEEF};
  localparam logic [41:0] EXP_E1 = {1'b0, 5'h12,   4'hA,   32'h1234_5678};
  localparam logic [41:0] EXP_E2 = {1'b1, 5'h1F,   4'hF,   32'h0000_0002};
  localparam logic [41:0] EXP_E7 = {1'b0, 5'd7,    4'd7,   32'hA5A5_0007};

  // ---------------------------------------------------------------- stimulus
  initial begin
    int busy;
    int held;
    int n;

    // Ring contents: entry n word0 at index 2n, word1 at 2n+1.
    mem[0]  = 32'h8003_0005; mem[1]  = 32'hDEAD_BEEF;
    mem[2]  = 32'h0012_FFFA; mem[3]  = 32'h1234_5678;
    mem[4]  = 32'h801F_000F; mem[5]  = 32'h0000_0002;
    mem[6]  = 32'h0003_0003; mem[7]  = 32'hC0DE_0003;
    mem[8]  = 32'h0004_0004; mem[9]  = 32'hC0DE_0004;
    mem[10] = 32'h0005_0005; mem[11] = 32'hC0DE_0005;
    mem[12] = 32'h0006_0006; mem[13] = 32'hC0DE_0006;
    mem[14] = 32'h7FE7_FFF7; mem[15] = 32'hA5A5_0007;

    sys_rst           = 1'b1;
    PhyReady          = 1'b1;
    inband_base       = 32'h0000_1000;
    inband_prod_index = 12'd0;
    mem_en            = 1'b1;
    auto_ack          = 1'b1;
    man_ack           = 1'b0;
    to_count          = 0;

    // Reset state.
    repeat (2) @(negedge sys_clk);
    check("rst_cons",    64'(inband_cons_index), 64'd0);
    check("rst_rdreq",   64'(bus.MemRdReq),      64'd0);
    check("rst_rdaddr",  64'(bus.MemRdAddr),     64'd0);
    check("rst_cmdreq",  64'(bus.CmdReq),        64'd0);
    check("rst_fields",  64'({bus.CmdWr, bus.CmdId, bus.CmdAddr, bus.Cmd}), 64'd0);
    check("rst_timeout", 64'(bus.CmdTimeout),    64'd0);
    sys_rst = 1'b0;

    // Empty ring: nothing fetched for 100 cycles.
    busy = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (bus.MemRdReq) busy++;
    end
    check("empty_rdreq_cycles", 64'(busy), 64'd0);
    check("empty_cons",         64'(inband_cons_index), 64'd0);

    // Single entry, cycle by cycle: IDLE, RD0, RD1, ISSUE, ADV.
    inband_prod_index = 12'd1;
    @(negedge sys_clk);
    check("e0_rd0_req",  64'(bus.MemRdReq),  64'd1);
    check("e0_rd0_addr", 64'(bus.MemRdAddr), 64'h1000);
    @(negedge sys_clk);
    check("e0_rd1_req",  64'(bus.MemRdReq),  64'd1);
    check("e0_rd1_addr", 64'(bus.MemRdAddr), 64'h1004);
    @(negedge sys_clk);
    check("e0_issue_req",    64'(bus.CmdReq),   64'd1);
    check("e0_issue_rdreq",  64'(bus.MemRdReq), 64'd0);
    check("e0_issue_fields", 64'({bus.CmdWr, bus.CmdId, bus.CmdAddr, bus.Cmd}), 64'(EXP_E0));
    @(negedge sys_clk);
    check("e0_adv_req",  64'(bus.CmdReq),        64'd0);
    check("e0_adv_cons", 64'(inband_cons_index), 64'd0);
    @(negedge sys_clk);
    check("e0_done_cons", 64'(inband_cons_index), 64'd1);

    // PhyReady gating: two pending entries, link down -> no read.
    rd_log.delete();
    cmd_log.delete();
    PhyReady          = 1'b0;
    inband_prod_index = 12'd3;
    repeat (20) @(negedge sys_clk);
    check("gate_reads", 64'(rd_log.size()),    64'd0);
    check("gate_cons",  64'(inband_cons_index), 64'd1);

    // Raise link; entry 1 ack held off for 10 cycles.
    auto_ack = 1'b0;
    PhyReady = 1'b1;
    repeat (3) @(negedge sys_clk);
    held = 0;
    repeat (10) begin
      if (bus.CmdReq) held++;
      @(negedge sys_clk);
    end
    check("hold_cycles", 64'(held), 64'd10);
    man_ack = 1'b1;
    @(negedge sys_clk);
    man_ack = 1'b0;
    check("hold_drop", 64'(bus.CmdReq), 64'd0);

    // Entry 2 with a stalled memory: request and address must hold.
    auto_ack = 1'b1;
    mem_en   = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("stall_req0",  64'(bus.MemRdReq),  64'd1);
    check("stall_addr0", 64'(bus.MemRdAddr), 64'h1010);
    repeat (3) @(negedge sys_clk);
    check("stall_req3",  64'(bus.MemRdReq),  64'd1);
    check("stall_addr3", 64'(bus.MemRdAddr), 64'h1010);
    mem_en = 1'b1;
    wait_cons(12'd3, 20, "gate_cons_end");
    check("gate_cmds", 64'(cmd_log.size()), 64'd2);
    if (cmd_log.size() == 2) begin
      check("gate_cmd_e1", 64'(cmd_log[0]), 64'(EXP_E1));
      check("gate_cmd_e2", 64'(cmd_log[1]), 64'(EXP_E2));
    end
    check("gate_read_count", 64'(rd_log.size()), 64'd4);

    // PhyReady dropping mid-entry does not abort the entry.
    inband_prod_index = 12'd4;
    n = 0;
    while (!bus.MemRdReq && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    check("phydrop_started", 64'(bus.MemRdReq), 64'd1);
    PhyReady = 1'b0;
    wait_cons(12'd4, 20, "phydrop_cons");
    check("phydrop_idle", 64'(bus.MemRdReq), 64'd0);
    PhyReady = 1'b1;

    // Reset mid-ISSUE, then refetch from entry 0.
    auto_ack          = 1'b0;
    inband_prod_index = 12'd5;
    n = 0;
    while (!bus.CmdReq && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    check("rstmid_issue", 64'(bus.CmdReq), 64'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rstmid_cmdreq", 64'(bus.CmdReq),        64'd0);
    check("rstmid_cons",   64'(inband_cons_index), 64'd0);
    sys_rst = 1'b0;
    rd_log.delete();
    cmd_log.delete();
    auto_ack = 1'b1;
    wait_cons(12'd5, 60, "refetch_cons");
    check("refetch_cmds", 64'(cmd_log.size()), 64'd5);
    if (rd_log.size() > 0)   check("refetch_addr", 64'(rd_log[0]),  64'h1000);
    if (cmd_log.size() > 0)  check("refetch_e0",   64'(cmd_log[0]), 64'(EXP_E0));

    // Wrap: move to cons=7, then consume entries 7 and 0.
    inband_prod_index = 12'd7;
    wait_cons(12'd7, 40, "prewrap_cons");
    rd_log.delete();
    cmd_log.delete();
    inband_prod_index = 12'd1;
    wait_cons(12'd1, 40, "wrap_cons");
    check("wrap_reads", 64'(rd_log.size()), 64'd4);
    if (rd_log.size() == 4) begin
      check("wrap_addr0", 64'(rd_log[0]), 64'h1038);
      check("wrap_addr1", 64'(rd_log[1]), 64'h103C);
      check("wrap_addr2", 64'(rd_log[2]), 64'h1000);
      check("wrap_addr3", 64'(rd_log[3]), 64'h1004);
    end
    if (cmd_log.size() == 2) begin
      check("wrap_cmd_e7", 64'(cmd_log[0]), 64'(EXP_E7));
      check("wrap_cmd_e0", 64'(cmd_log[1]), 64'(EXP_E0));
    end

    // Ring full (prod = cons-1): seven entries drained.
    cmd_log.delete();
    inband_prod_index = 12'd0;
    wait_cons(12'd0, 100, "full_cons");
    check("full_cmds", 64'(cmd_log.size()), 64'd7);

    // Ack never arrives.
    auto_ack          = 1'b0;
    to_count          = 0;
    inband_prod_index = 12'd1;
    n = 0;
    while (!bus.CmdReq && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    check("noack_issue", 64'(bus.CmdReq), 64'd1);
    held = 0;
`ifdef HS_INBAND_CONS_TIMEOUT_EN
    while (bus.CmdReq && held < 40) begin
      held++;
      @(negedge sys_clk);
    end
    check("timeout_held",  64'(held),           64'd16);
    check("timeout_pulse", 64'(bus.CmdTimeout), 64'd1);
    wait_cons(12'd1, 5, "timeout_cons");
    @(negedge sys_clk);
    check("timeout_count", 64'(to_count),       64'd1);
    check("timeout_clear", 64'(bus.CmdTimeout), 64'd0);
`else
    while (bus.CmdReq && held < 20) begin
      held++;
      @(negedge sys_clk);
    end
    check("noto_held",    64'(held),     64'd20);
    check("noto_pulse",   64'(to_count), 64'd0);
    check("noto_timeout", 64'(bus.CmdTimeout), 64'd0);
    man_ack = 1'b1;
    @(negedge sys_clk);
    man_ack = 1'b0;
    wait_cons(12'd1, 5, "noto_cons");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hs_inband_cons
